// File: rtl/stream_rr_arbiter.sv
// Round-robin arbiter sharing one registered valid/ready data+strobe stream
// between NUM_IN requesters, with bursts of up to MAX_BURST beats per grant.
module stream_rr_arbiter #(
  parameter int NUM_IN     = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int IDX_WIDTH  = ($clog2(NUM_IN) > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_IN*DATA_WIDTH-1:0]   s_data,
  input  logic [NUM_IN*STRB_WIDTH-1:0]   s_strb,
  input  logic [NUM_IN-1:0]              s_valid,
  output logic [NUM_IN-1:0]              s_ready,
  output logic [DATA_WIDTH-1:0]          m_data,
  output logic [STRB_WIDTH-1:0]          m_strb,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [IDX_WIDTH-1:0]           grant_idx,
  output logic                           grant_active
);

  localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);
  localparam int SUM_WIDTH = IDX_WIDTH + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]            state_r;
  logic [IDX_WIDTH-1:0]  grant_idx_r;
  logic [IDX_WIDTH-1:0]  rr_ptr_r;
  logic [CNT_WIDTH-1:0]  beat_cnt_r;
  logic                  m_valid_r;
  logic [DATA_WIDTH-1:0] m_data_r;
  logic [STRB_WIDTH-1:0] m_strb_r;

  logic                  out_free_s;
  logic                  gnt_valid_s;
  logic                  up_hs_s;
  logic                  last_beat_s;
  logic                  found_s;
  logic [IDX_WIDTH-1:0]  winner_s;
  logic [SUM_WIDTH-1:0]  cand_s;
  logic [IDX_WIDTH-1:0]  next_ptr_s;
  logic [DATA_WIDTH-1:0] sel_data_s;
  logic [STRB_WIDTH-1:0] sel_strb_s;

  assign grant_active = (state_r == ST_GRANT);
  assign grant_idx    = grant_idx_r;
  assign m_valid      = m_valid_r;
  assign m_data       = m_data_r;
  assign m_strb       = m_strb_r;

  assign out_free_s  = !m_valid_r || m_ready;
  assign gnt_valid_s = s_valid[grant_idx_r];
  assign up_hs_s     = grant_active && out_free_s && gnt_valid_s;
  assign last_beat_s = (beat_cnt_r == CNT_WIDTH'(MAX_BURST - 1));
  assign next_ptr_s  = (grant_idx_r == IDX_WIDTH'(NUM_IN - 1)) ? '0
                                                               : grant_idx_r + IDX_WIDTH'(1);

  // Ready goes only to the granted requester, and only when the output stage can take a beat
  always_comb begin
    s_ready = '0;
    if (grant_active && out_free_s) begin
      s_ready[grant_idx_r] = 1'b1;
    end else begin
      s_ready = '0;
    end
  end

  // Round-robin search: first valid requester at or above the pointer, wrapping at NUM_IN
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    cand_s   = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand_s = {1'b0, rr_ptr_r} + SUM_WIDTH'(k);
      if (cand_s >= SUM_WIDTH'(NUM_IN)) begin
        cand_s = cand_s - SUM_WIDTH'(NUM_IN);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && s_valid[cand_s[IDX_WIDTH-1:0]]) begin
        found_s  = 1'b1;
        winner_s = cand_s[IDX_WIDTH-1:0];
      end else begin
        found_s  = found_s;
      end
    end
  end

  // Data/strobe mux selecting the granted requester's slice
  always_comb begin
    sel_data_s = '0;
    sel_strb_s = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (grant_idx_r == IDX_WIDTH'(i)) begin
        sel_data_s = s_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb_s = s_strb[i*STRB_WIDTH +: STRB_WIDTH];
      end else begin
        sel_data_s = sel_data_s;
        sel_strb_s = sel_strb_s;
      end
    end
  end

  // Grant FSM: arbitrate in IDLE, count beats and release in GRANT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      grant_idx_r <= '0;
      rr_ptr_r    <= '0;
      beat_cnt_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (found_s) begin
            state_r     <= ST_GRANT;
            grant_idx_r <= winner_s;
            beat_cnt_r  <= '0;
          end
        end
        ST_GRANT: begin
          // A dropped valid ends the burst even while the output is stalled
          if (!gnt_valid_s) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= next_ptr_s;
          end else if (up_hs_s) begin
            beat_cnt_r <= beat_cnt_r + CNT_WIDTH'(1);
            if (last_beat_s) begin
              state_r  <= ST_IDLE;
              rr_ptr_r <= next_ptr_s;
            end
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output register: loads on upstream accept, drains on m_ready independent of the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_r <= 1'b0;
      m_data_r  <= '0;
      m_strb_r  <= '0;
    end else if (up_hs_s) begin
      m_valid_r <= 1'b1;
      m_data_r  <= sel_data_s;
      m_strb_r  <= sel_strb_s;
    end else if (m_ready) begin
      m_valid_r <= 1'b0;
    end
  end

endmodule
